// File: rtl/mem_arbiter_if.sv
// Request/response bus shared by the fetch port, data port and unified memory port.
// master drives requests and consumes responses; slave accepts requests and returns responses.
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned MASKW = XLEN / 8;

    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_addr;
    logic             req_wen;
    logic [MASKW-1:0] req_wmask;
    logic [XLEN-1:0]  req_wdata;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_data;

    modport master (
        output req_valid, req_addr, req_wen, req_wmask, req_wdata,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wmask, req_wdata,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise the data port always wins.
module mem_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  imem,
    mem_arbiter_if.slave  dmem,
    mem_arbiter_if.master mem,
    output logic          protocol_err
);
    localparam int unsigned MASKW = XLEN / 8;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    typedef enum logic {OwnImem, OwnDmem} owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q;
    logic [XLEN-1:0]  addr_q;
    logic             wen_q;
    logic [MASKW-1:0] wmask_q;
    logic [XLEN-1:0]  wdata_q;
    logic             imem_resp_valid_q, dmem_resp_valid_q;
    logic [XLEN-1:0]  imem_resp_data_q, dmem_resp_data_q;
    logic             protocol_err_q;

    logic grant_imem, grant_dmem;
    logic dmem_wins_conflict;
    logic resp_accept;

`ifdef MEM_ARB_RR_EN
    owner_e last_grant_q;
    assign dmem_wins_conflict = (last_grant_q == OwnImem);
`else
    assign dmem_wins_conflict = 1'b1;
`endif

    // Fetches never carry write payload.
    logic unused_imem_payload;
    assign unused_imem_payload = ^{imem.req_wen, imem.req_wmask, imem.req_wdata};

    assign resp_accept = (state_q == StWait) && mem.resp_valid;

    always_comb begin
        state_d    = state_q;
        grant_imem = 1'b0;
        grant_dmem = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dmem.req_valid && (!imem.req_valid || dmem_wins_conflict)) begin
                    grant_dmem = 1'b1;
                end else if (imem.req_valid) begin
                    grant_imem = 1'b1;
                end
                if (grant_imem || grant_dmem) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem.req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem.resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            owner_q           <= OwnDmem;
            addr_q            <= '0;
            wen_q             <= 1'b0;
            wmask_q           <= '0;
            wdata_q           <= '0;
            imem_resp_valid_q <= 1'b0;
            dmem_resp_valid_q <= 1'b0;
            imem_resp_data_q  <= '0;
            dmem_resp_data_q  <= '0;
            protocol_err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q      <= OwnImem;
`endif
        end else begin
            state_q           <= state_d;
            imem_resp_valid_q <= 1'b0;
            dmem_resp_valid_q <= 1'b0;

            if (grant_dmem) begin
                addr_q  <= dmem.req_addr;
                wen_q   <= dmem.req_wen;
                wmask_q <= dmem.req_wmask;
                wdata_q <= dmem.req_wdata;
                owner_q <= OwnDmem;
            end else if (grant_imem) begin
                addr_q  <= imem.req_addr;
                wen_q   <= 1'b0;
                wmask_q <= '0;
                wdata_q <= '0;
                owner_q <= OwnImem;
            end

`ifdef MEM_ARB_RR_EN
            if (grant_dmem) begin
                last_grant_q <= OwnDmem;
            end else if (grant_imem) begin
                last_grant_q <= OwnImem;
            end
`endif

            if (resp_accept) begin
                if (owner_q == OwnDmem) begin
                    dmem_resp_valid_q <= 1'b1;
                    dmem_resp_data_q  <= mem.resp_data;
                end else begin
                    imem_resp_valid_q <= 1'b1;
                    imem_resp_data_q  <= mem.resp_data;
                end
            end

            // A response with nothing outstanding is dropped but remembered until reset.
            if (mem.resp_valid && (state_q != StWait)) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    assign imem.req_ready  = grant_imem;
    assign dmem.req_ready  = grant_dmem;
    assign imem.resp_valid = imem_resp_valid_q;
    assign imem.resp_data  = imem_resp_data_q;
    assign dmem.resp_valid = dmem_resp_valid_q;
    assign dmem.resp_data  = dmem_resp_data_q;

    assign mem.req_valid = (state_q == StIssue);
    assign mem.req_addr  = addr_q;
    assign mem.req_wen   = wen_q;
    assign mem.req_wmask = wmask_q;
    assign mem.req_wdata = wdata_q;

    assign protocol_err = protocol_err_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory between the core's instruction-fetch requester and data requester.
- Sits between the core's imem/dmem ports and a unified memory.
- Accepts at most one transaction at a time, forwards it to memory, and routes the response back to its owner.
- Fixed data-priority arbitration by default; round-robin is an optional compile-time feature.

Parameters:
XLEN, 32, address and data width in bits; must be a multiple of 8
MASKW, XLEN/8, byte write-mask width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
imem_req_valid  in  1  fetch request present
imem_req_ready  out  1  fetch request accepted this cycle when valid&ready
imem_req_addr  in  XLEN  fetch byte address
imem_resp_valid  out  1  one-cycle pulse; fetch data valid
imem_resp_data  out  XLEN  fetch read data
dmem_req_valid  in  1  data request present
dmem_req_ready  out  1  data request accepted when valid&ready
dmem_req_addr  in  XLEN  data byte address
dmem_req_wen  in  1  1 = store, 0 = load
dmem_req_wmask  in  MASKW  byte enables for stores
dmem_req_wdata  in  XLEN  store data
dmem_resp_valid  out  1  one-cycle pulse; load data or store completion
dmem_resp_data  out  XLEN  load data (for a store, passes mem_resp_data unchanged)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  registered address
mem_req_wen  out  1  registered write enable (0 for fetches)
mem_req_wmask  out  MASKW  registered byte mask (0 for fetches)
mem_req_wdata  out  XLEN  registered store data (0 for fetches)
mem_resp_valid  in  1  memory response (reads and writes both respond)
mem_resp_data  in  XLEN  memory read data
protocol_err  out  1  sticky: memory response arrived with no transaction outstanding

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset values: state = IDLE; all outputs 0; owner = DMEM; last_grant = IMEM.
- IDLE:
  - Grant is combinational from the valids; only the granted port sees ready = 1.
  - dmem only valid: dmem_req_ready = 1. imem only valid: imem_req_ready = 1.
  - Both valid: dmem wins (see Optional Feature for round-robin).
  - On handshake: latch addr/wen/wmask/wdata (zeros for imem) into mem_req_* registers; record owner; update last_grant; go to ISSUE next cycle.
  - Neither valid: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1; mem_req_* held stable.
  - mem_req_ready = 1: drop mem_req_valid next cycle and go to WAIT.
  - mem_req_ready = 0: stay in ISSUE indefinitely with the request unchanged.
- WAIT:
  - On mem_resp_valid: register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid for exactly one cycle (the next cycle), and return to IDLE.
  - The non-owner's resp_valid stays 0.
- Response latency: the requester's resp_valid rises 1 cycle after mem_resp_valid.
- Minimum occupancy: request handshake to next possible handshake is 3 cycles (IDLE, ISSUE, WAIT with same-cycle ready and next-cycle response, then back to IDLE).
- Both imem_req_ready and dmem_req_ready are 0 in ISSUE and WAIT. A new request can be accepted in the same cycle that a resp_valid pulse is emitted, because the FSM is already back in IDLE.
- resp_data holds its last value between pulses.
- mem_resp_valid in IDLE or ISSUE: response ignored, no resp pulse, protocol_err set to 1 and held until reset.
- Memory is required to respond no earlier than the cycle after acceptance.
- Reset mid-transaction: FSM returns to IDLE and the outstanding transaction is abandoned, with no resp pulse. A late memory response for it sets protocol_err.
- Requesters must hold valid and payload stable until ready. The arbiter does not buffer unaccepted requests.

Optional Feature:
MEM_ARB_RR_EN
- Defined: on simultaneous imem/dmem valid in IDLE, grant the port opposite to last_grant (round-robin).
- Undefined: dmem always wins conflicts and last_grant is unused (may be optimised away).
- Single-requester behaviour is identical either way.

Test Plan:
1. Load: dmem load addr 0x100, memory ready immediately, responds 0xDEADBEEF 2 cycles later -> dmem_resp_valid one-cycle pulse with 0xDEADBEEF; imem_resp_valid stays 0.
2. Store: dmem store addr 0x8, wmask 0b0011, wdata 0x0000ABCD -> mem_req_wen = 1, wmask = 0b0011, wdata = 0x0000ABCD held through 3 cycles of mem_req_ready = 0; one dmem_resp_valid pulse after memory responds.
3. Conflict: imem and dmem both valid for 4 back-to-back transactions, memory with 1-cycle response.
   - Without MEM_ARB_RR_EN: grants D,D,D,D.
   - With it: grants D,I,D,I (last_grant = IMEM at reset).
4. Fetch: imem fetch addr 0x0, memory returns 0x00000013 -> imem_resp_data = 0x13; mem_req_wen = 0 and mem_req_wmask = 0 during ISSUE.
5. Spurious response: mem_resp_valid pulsed while in IDLE -> protocol_err = 1 and stays 1 until reset; no resp pulses; next transaction completes normally.
6. Reset mid-transaction: assert reset while in WAIT -> next cycle state IDLE, all outputs 0; subsequent mem_resp_valid sets protocol_err; a new imem request is then serviced normally.
